ecb_serial_ctrl: RTL and testbench
==================================

Name: ecb_serial_ctrl

Overview:
Bit-serial ECB encryption controller. It accepts a BLOCK_W-bit plaintext block over a valid/ready handshake and feeds it one bit per cycle through a single ecb_enc_1bit XOR cell, paired with the matching bit of a stored key. The ciphertext is reassembled in a shift register and presented on a valid/ready output. One key register serves all blocks, as ECB requires. The block sits between the host-side block FIFO and the ciphertext sink.

Parameters:
BLOCK_W, 8, block and key width in bits; legal range is 2 or more.
CNT_W, 16, width of the completed-block counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
key_load  input  1  loads key_in when key_ready is high.
key_in  input  BLOCK_W  key value.
key_ready  output  1  key register may be written (IDLE only).
key_loaded  output  1  a key has been loaded since reset.
in_valid  input  1  plaintext block valid.
in_data  input  BLOCK_W  plaintext block.
in_ready  output  1  controller accepts a block.
out_valid  output  1  ciphertext block valid.
out_data  output  BLOCK_W  ciphertext block.
out_ready  input  1  sink accepts the ciphertext.
busy  output  1  state is not IDLE.
blk_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - Key register, PT shift register, CT shift register and bit counter all clear to 0.
  - key_loaded=0, out_valid=0, out_data=0, busy=0, blk_cnt=0.
  - Reset mid-block discards the block; no partial output is ever produced.
- States:
  - IDLE: waiting for a key or a block.
  - SHIFT: serial XOR in progress.
  - DONE: holding the output.
- Combinational outputs:
  - key_ready = (state==IDLE).
  - in_ready = (state==IDLE) & key_loaded & ~key_load.
  - busy = (state!=IDLE).
- IDLE behaviour:
  - key_load=1 latches key_in and sets key_loaded=1 on that edge.
  - key_load has priority: when key_load and in_valid are both high, only the key is taken and the block waits.
  - In SHIFT or DONE, key_load is ignored and the key is unchanged.
- IDLE to SHIFT: on the edge where in_valid & in_ready, latch in_data into the PT shift register and set bit counter=0.
- SHIFT behaviour:
  - XOR cell inputs are PT shift register bit 0 and key bit [counter], selected by a mux. Processing is LSB first.
  - Each edge shifts the cell output into the MSB of the CT shift register, shifts the PT register right by one, and increments the counter.
  - On the edge where counter==BLOCK_W-1, the transition to DONE happens. out_data then equals in_data ^ key, with bit order preserved.
- Latency: with the accept edge as E0, bits are processed on edges E1..E_BLOCK_W. out_valid goes high after edge E_BLOCK_W.
- DONE behaviour:
  - out_valid=1 and out_data is held stable until out_ready=1.
  - On the out handshake edge: go to IDLE, out_valid clears, blk_cnt increments and wraps modulo 2^CNT_W.
  - out_data keeps its last value after the handshake.
- Concurrency and ordering:
  - No overlap between blocks: the next block is accepted at the earliest one cycle after the output handshake.
  - Back-to-back throughput is one block per BLOCK_W+2 cycles.
  - in_ready=0 and key_ready=0 throughout SHIFT and DONE.
  - With key_loaded=0, in_valid is never accepted: in_ready stays 0.

Decomposition:
- Shared package ecb_pkg holds:
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE);
  - the default BLOCK_W constant;
  - the function computing the counter width as clog2(BLOCK_W).
- Sub-module: exactly one instance of the existing ecb_enc_1bit cell, used as the serial datapath. Its K, PT and CT ports connect to the key mux output, PT shift register bit 0 and the CT shift-in respectively.
- Counter, shift registers and FSM stay in this module.

Test Plan (all with BLOCK_W=8):
1. Key load and single block: reset, load key 0xA5, send in_data 0x3C with out_ready=1. out_valid rises 8 edges after acceptance, out_data=0x99, blk_cnt=1, in_ready returns 1 on the next cycle.
2. Backpressure: key 0xFF, send 0x0F, hold out_ready=0 for 20 cycles. out_valid stays 1 with out_data stable at 0xF0, in_ready and key_ready stay 0. Release out_ready: one handshake, blk_cnt increments once.
3. No key: after reset, hold in_valid=1 with 0x12. in_ready stays 0 and nothing is accepted. Then load key 0x00: the block is accepted and out_data=0x12.
4. Simultaneous key_load and in_valid in IDLE: key 0x0F is taken, the block is not taken that cycle, then the block 0xF0 is taken. out_data=0xFF. Also assert key_load=1 with 0x55 during SHIFT: out_data is unaffected and the stored key is still 0x0F.
5. Reset mid-operation: drop rst_n at bit 4 of a block. All outputs go to reset values immediately, key_loaded=0, and no out_valid pulse occurs after reset is released.
6. Streaming and wrap: with CNT_W=2, send 5 back-to-back blocks under random out_ready. Each CT must equal PT ^ key, blocks must be accepted exactly BLOCK_W+2 cycles apart under continuous out_ready, and blk_cnt must read 1 after 5 handshakes.

Source files
------------

// File: rtl/ecb_pkg.sv
// Shared types and constants for the bit-serial ECB controller.
// Holds the FSM state encoding and counter width helper.
package ecb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int BLOCK_W_DEF = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/ecb_enc_1bit.sv
// Single-bit ECB encryption cell.
// One plaintext bit combined with one key bit.
module ecb_enc_1bit (
  input  logic k,
  input  logic pt,
  output logic ct
);

  assign ct = pt ^ k;

endmodule

// File: rtl/ecb_serial_ctrl.sv
// Bit-serial ECB encryption controller.
// One XOR cell per cycle, LSB first, valid/ready on both sides.
module ecb_serial_ctrl
  import ecb_pkg::*;
#(
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_load,
  input  logic [BLOCK_W-1:0] key_in,
  output logic               key_ready,
  output logic               key_loaded,
  input  logic               in_valid,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [BLOCK_W-1:0] out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int CW = cnt_width(BLOCK_W);
  localparam logic [CW-1:0] LAST = CW'(BLOCK_W - 1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [BLOCK_W-1:0] pt_q, pt_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               key_loaded_q, key_loaded_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  logic key_bit;
  logic ct_bit;

  assign key_bit = key_q[cnt_q];

  ecb_enc_1bit u_enc (
    .k  (key_bit),
    .pt (pt_q[0]),
    .ct (ct_bit)
  );

  assign key_ready  = (state_q == ST_IDLE);
  assign in_ready   = (state_q == ST_IDLE) & key_loaded_q & ~key_load;
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_data   = ct_q;
  assign key_loaded = key_loaded_q;
  assign blk_cnt    = blk_cnt_q;

  // Next-state: key load wins in IDLE, then serial shift, then hold.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    cnt_d        = cnt_q;
    key_loaded_d = key_loaded_q;
    blk_cnt_d    = blk_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          key_d        = key_in;
          key_loaded_d = 1'b1;
        end else if (in_valid && key_loaded_q) begin
          pt_d    = in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ct_d  = {ct_bit, ct_q[BLOCK_W-1:1]};
        pt_d  = pt_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d   = ST_IDLE;
          blk_cnt_d = blk_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      pt_q         <= '0;
      ct_q         <= '0;
      cnt_q        <= '0;
      key_loaded_q <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      cnt_q        <= cnt_d;
      key_loaded_q <= key_loaded_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_ecb_serial_ctrl.sv
// Self-checking bench for ecb_serial_ctrl.
// Vector table plus directed multi-cycle sequences.
module tb_ecb_serial_ctrl;

  localparam int BW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_load = 1'b0;
  logic [BW-1:0] key_in = '0;
  logic          key_ready;
  logic          key_loaded;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] blk_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ecb_serial_ctrl #(
    .BLOCK_W (BW),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .key_loaded (key_loaded),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .blk_cnt    (blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] key;
    logic [BW-1:0] pt;
    logic [BW-1:0] ct;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    key_load  = 1'b0;
    key_in    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_key(input logic [BW-1:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
    chk("key_loaded", key_loaded, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic send(input logic [BW-1:0] pt, output int lat);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = pt;
    #1;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("accept_timeout", w < 50, 1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
  endtask

  task automatic stream(input bit rnd, input logic [BW-1:0] k);
    logic [BW-1:0] pts[5];
    int sent, got, cyc, last_acc;
    bit acc, hs;
    pts[0] = 8'h11; pts[1] = 8'h22; pts[2] = 8'hC3;
    pts[3] = 8'h7E; pts[4] = 8'h00;
    sent = 0; got = 0; cyc = 0; last_acc = -1;
    do_reset();
    load_key(k);
    while (got < 5 && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < 5);
      in_data   = pts[(sent < 5) ? sent : 0];
      #1;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        chk("stream_ct", out_data, pts[got] ^ k);
        got++;
      end
      if (acc) begin
        if (!rnd && last_acc >= 0)
          chk("stream_gap", cyc - last_acc, BW + 2);
        last_acc = cyc;
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_done", got, 5);
    chk("blk_cnt_wrap", blk_cnt, 1);
  endtask

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{key: 8'hA5, pt: 8'h3C, ct: 8'h99};
    vecs[1] = '{key: 8'hFF, pt: 8'h0F, ct: 8'hF0};
    vecs[2] = '{key: 8'h00, pt: 8'h12, ct: 8'h12};
    vecs[3] = '{key: 8'h0F, pt: 8'hF0, ct: 8'hFF};
    vecs[4] = '{key: 8'h5A, pt: 8'hC3, ct: 8'h99};
    vecs[5] = '{key: 8'h80, pt: 8'h01, ct: 8'h81};

    // reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_key_ready", key_ready, 1);

    // table-driven single blocks
    for (int i = 0; i < 6; i++) begin
      do_reset();
      load_key(vecs[i].key);
      out_ready = 1'b1;
      send(vecs[i].pt, lat);
      chk("vec_latency", lat, BW);
      chk("vec_ct", out_data, vecs[i].ct);
      chk("vec_in_ready_done", in_ready, 0);
      tick();
      out_ready = 1'b0;
      chk("vec_blk_cnt", blk_cnt, 1);
      chk("vec_valid_clr", out_valid, 0);
      chk("vec_in_ready_back", in_ready, 1);
      chk("vec_ct_hold", out_data, vecs[i].ct);
    end

    // backpressure
    do_reset();
    load_key(8'hFF);
    out_ready = 1'b0;
    send(8'h0F, lat);
    chk("bp_latency", lat, BW);
    for (int c = 0; c < 20; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'hF0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_key_ready", key_ready, 0);
      tick();
    end
    chk("bp_cnt_before", blk_cnt, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_cnt_after", blk_cnt, 1);
    chk("bp_valid_clr", out_valid, 0);
    tick();
    chk("bp_cnt_once", blk_cnt, 1);

    // no key: block must wait
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h12;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("nokey_in_ready", in_ready, 0);
      chk("nokey_busy", busy, 0);
    end
    key_load = 1'b1;
    key_in   = 8'h00;
    #1;
    chk("nokey_kl_rdy", in_ready, 0);
    tick();
    key_load = 1'b0;
    chk("nokey_not_taken", busy, 0);
    #1;
    chk("nokey_rdy_now", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("nokey_taken", busy, 1);
    wait_valid(lat);
    chk("nokey_ct", out_data, 8'h12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // key_load priority and key_load ignored while busy
    do_reset();
    key_load = 1'b1;
    key_in   = 8'h0F;
    in_valid = 1'b1;
    in_data  = 8'hF0;
    #1;
    chk("prio_in_ready", in_ready, 0);
    tick();
    key_load = 1'b0;
    chk("prio_not_taken", busy, 0);
    chk("prio_key_loaded", key_loaded, 1);
    tick();
    in_valid = 1'b0;
    chk("prio_taken", busy, 1);
    key_load = 1'b1;
    key_in   = 8'h55;
    for (int c = 0; c < 3; c++) begin
      chk("shift_key_ready", key_ready, 0);
      tick();
    end
    key_load = 1'b0;
    wait_valid(lat);
    chk("prio_ct", out_data, 8'hFF);
    out_ready = 1'b1;
    tick();
    send(8'h00, lat);
    chk("key_kept", out_data, 8'h0F);
    tick();
    out_ready = 1'b0;

    // asynchronous reset mid-block
    do_reset();
    load_key(8'h77);
    in_valid = 1'b1;
    in_data  = 8'h99;
    #1;
    chk("mid_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_key_loaded", key_loaded, 0);
    chk("mid_rst_blk_cnt", blk_cnt, 0);
    chk("mid_rst_key_ready", key_ready, 1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid || busy) seen = 1'b1;
    end
    out_ready = 1'b0;
    chk("mid_no_ghost", seen, 0);

    // streaming: random backpressure, then continuous
    stream(1'b1, 8'h3C);
    stream(1'b0, 8'hA7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
